rvc_asap_5pl_dmem_arb: RTL
==========================

# rvc_asap_5pl_dmem_arb

Two-requester arbiter that shares the single data-memory port in `rvc_asap_5pl_mem_wrap` between the core's memory stage and a debug/backdoor-load port. The debug port is used for program/data load and snapshot readout without XMR `force`. The block issues grants, routes the winner onto the memory port, and returns 1-cycle-latency read data to the owner. A starvation guard and a debug burst lock sequence fair access.

## Interface
Parameters:
- `MAX_WAIT`, 8: consecutive denied debug cycles before debug is forced to win (1..255).
- `ADDR_W`, 32: address width.

Ports:
- `Clock` in 1: the single clock; all state updates on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `CoreReq` in 1: core access request.
- `CoreWrEn` in 1: 1 = write, 0 = read.
- `CoreAddr` in ADDR_W: byte address.
- `CoreWrData` in 32: write data.
- `CoreByteEn` in 4: byte enables for writes.
- `CoreGnt` out 1: core access accepted this cycle. A low `CoreGnt` while `CoreReq` is high is a core stall.
- `CoreRdData` out 32: read data returned to the core.
- `CoreRdValid` out 1: `CoreRdData` is valid this cycle.
- `DbgReq`, `DbgWrEn`, `DbgAddr`, `DbgWrData`, `DbgByteEn`: debug-port equivalents of the core request signals, same widths.
- `DbgLock` in 1: asks to hold ownership across a burst.
- `DbgGnt`, `DbgRdData`, `DbgRdValid` out: debug-port equivalents of the core grant and return signals.
- `MemRdEn` out 1: memory read strobe.
- `MemWrEn` out 4: per-byte memory write strobe.
- `MemAddr` out ADDR_W: memory address.
- `MemWrData` out 32: memory write data.
- `MemRdData` in 32: memory read data, valid 1 cycle after `MemRdEn`.

## Operation
- FSM states:
  - ARB: grant decided every cycle.
  - LOCKED: debug owns the port.
- Reset values: state ARB, `WaitCnt`=0, `RdOwner`=core, `CoreRdValid`=0, `DbgRdValid`=0.
- ARB grant rules, evaluated in order:
  1. Only one requester active → that requester wins.
  2. Both requesters active and `WaitCnt`==MAX_WAIT → debug wins.
  3. Both requesters active otherwise → core wins.
- At most one of `CoreGnt`/`DbgGnt` is high in any cycle. A grant implies its request is high.
- `WaitCnt` (8-bit, saturating at MAX_WAIT):
  - Increments on each cycle with `DbgReq` && !`DbgGnt`.
  - Clears on `DbgGnt` or on !`DbgReq`.
- ARB→LOCKED: on a cycle with `DbgGnt` && `DbgLock`.
- In LOCKED:
  - `CoreGnt`=0 unconditionally.
  - `DbgGnt`=`DbgReq`.
  - `WaitCnt` holds 0.
- LOCKED→ARB: on the first edge that samples `DbgLock`=0. In that final cycle `DbgGnt` still follows `DbgReq`.
- Memory mux: when a grant is issued, the winner's address and data drive `Mem*`.
  - `MemRdEn` = grant && !WrEn.
  - `MemWrEn` = {4{grant && WrEn}} & ByteEn.
  - With no grant, all strobes are 0 and address/data are don't-care.
- Read return:
  - A granted read registers `RdOwner`.
  - Next cycle, the owner's `*RdValid`=1.
  - `CoreRdData` and `DbgRdData` both equal `MemRdData`; only the owner's valid is asserted.
- Back-to-back reads from alternating owners return in grant order with no bubbles.

## Timing
- `CoreGnt`/`DbgGnt` are combinational from the requests and the registered state. There is no register between request and grant.
- Write commits at the edge that ends the grant cycle.
- Read latency: exactly 1 cycle from grant to `*RdValid`.
- The debug request cannot stall longer than MAX_WAIT+1 cycles while unlocked.
- Reset asserted mid-lock or mid-read:
  - Grants and memory strobes go to 0 asynchronously.
  - State returns to ARB.
  - A pending `RdValid` is dropped and not re-issued after reset.
- `DbgLock` with no debug grant has no effect.

## Configuration
- `RVC_ASAP_ARB_STARVE_EN`
  - Defined: starvation guard active as described above.
  - Undefined: strict core priority. `WaitCnt` is removed, and debug wins in ARB only when `CoreReq`=0. LOCKED behaviour is unchanged.

## Test plan
- Reset release, no requests → all grants 0, `MemRdEn`=0, `MemWrEn`=4'h0, both RdValid 0.
- Core write `CoreAddr`=0x2000, data 0xDEADBEEF, ByteEn 4'hF; then core read of the same address → write granted same cycle; read grant then `CoreRdValid`=1 one cycle later with 0xDEADBEEF; `DbgRdValid`=0.
- `CoreReq` and `DbgReq` held high continuously, MAX_WAIT=8, guard enabled → `DbgGnt` on cycles 9, 18, 27, …; core granted all other cycles. Guard disabled → `DbgGnt` never asserts.
- Debug burst with `DbgLock`=1 for 16 writes while `CoreReq`=1 → `CoreGnt`=0 for all 16 cycles. Core is granted the cycle after `DbgLock` drops.
- Alternating reads core@0x2000 / debug@0x2004 on consecutive cycles → `CoreRdValid` and `DbgRdValid` alternate each cycle with correct data.
- `Rst` pulsed while LOCKED with a read in flight → no `*RdValid` after reset; next core request is granted immediately in ARB.

Source files
------------

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// Data-memory port arbiter: core memory stage vs. debug/backdoor port, 1-cycle read return.
// Optional starvation guard for the debug port: define RVC_ASAP_ARB_STARVE_EN.
module rvc_asap_5pl_dmem_arb #(
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = 32
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              CoreReq,
  input  logic              CoreWrEn,
  input  logic [ADDR_W-1:0] CoreAddr,
  input  logic [31:0]       CoreWrData,
  input  logic [3:0]        CoreByteEn,
  output logic              CoreGnt,
  output logic [31:0]       CoreRdData,
  output logic              CoreRdValid,
  input  logic              DbgReq,
  input  logic              DbgWrEn,
  input  logic [ADDR_W-1:0] DbgAddr,
  input  logic [31:0]       DbgWrData,
  input  logic [3:0]        DbgByteEn,
  input  logic              DbgLock,
  output logic              DbgGnt,
  output logic [31:0]       DbgRdData,
  output logic              DbgRdValid,
  output logic              MemRdEn,
  output logic [3:0]        MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t state, state_nxt;
  logic   core_gnt, dbg_gnt;
  logic   dbg_starved;
  logic   win_wr;
  logic   rd_vld_p1, rd_dbg_p1;

`ifdef RVC_ASAP_ARB_STARVE_EN
  logic [7:0] wait_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= 8'(MAX_WAIT)) ? 8'(MAX_WAIT) : v + 8'd1;
  endfunction

  // Counts consecutive denied debug cycles; any grant or idle debug cycle clears it.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      wait_cnt <= 8'd0;
    end else if (DbgReq && !dbg_gnt) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  assign dbg_starved = (wait_cnt == 8'(MAX_WAIT));
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign dbg_starved = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:    if (dbg_gnt && DbgLock) state_nxt = ST_LOCKED;
      ST_LOCKED: if (!DbgLock)           state_nxt = ST_ARB;
      default:                           state_nxt = ST_ARB;
    endcase
  end

  // Grants are combinational so a winner reaches memory in its request cycle; reset kills them at once.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!Rst) begin
      case (state)
        ST_ARB: begin
          if (DbgReq && (!CoreReq || dbg_starved)) begin
            dbg_gnt = 1'b1;
          end else begin
            core_gnt = CoreReq;
          end
        end
        ST_LOCKED: dbg_gnt = DbgReq;
        default: begin
          core_gnt = 1'b0;
          dbg_gnt  = 1'b0;
        end
      endcase
    end
  end

  assign CoreGnt   = core_gnt;
  assign DbgGnt    = dbg_gnt;
  assign win_wr    = dbg_gnt ? DbgWrEn : CoreWrEn;
  assign MemAddr   = dbg_gnt ? DbgAddr : CoreAddr;
  assign MemWrData = dbg_gnt ? DbgWrData : CoreWrData;
  assign MemRdEn   = (core_gnt || dbg_gnt) && !win_wr;
  assign MemWrEn   = {4{(core_gnt || dbg_gnt) && win_wr}} & (dbg_gnt ? DbgByteEn : CoreByteEn);

  // Stage p1: read data returns one cycle after the grant, tagged with its owner.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      rd_vld_p1 <= 1'b0;
      rd_dbg_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= MemRdEn;
      if (MemRdEn) rd_dbg_p1 <= dbg_gnt;
    end
  end

  assign CoreRdValid = rd_vld_p1 && !rd_dbg_p1;
  assign DbgRdValid  = rd_vld_p1 && rd_dbg_p1;
  assign CoreRdData  = MemRdData;
  assign DbgRdData   = MemRdData;

endmodule
